// File: rtl/uart_ctrl.sv
// uart_ctrl: runtime-configurable full-duplex UART core.
//   Baud/parity/stop are programmable; TX and RX use valid/ready handshakes.
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_baud_div                      tick period minus 1 (bit = (div+1)*G_OVERSAMPLE clocks)
//   i_parity_mode, i_two_stop       00/11 none, 01 even, 10 odd; TX two stop bits
//   i_tx_valid/o_tx_ready/i_tx_data TX word handshake
//   o_tx, o_tx_busy                 serial out (idle high), TX frame in flight
//   i_rx                            asynchronous serial in
//   o_rx_valid/i_rx_ready/o_rx_data RX holding register handshake
//   o_rx_parity_err/frame_err/break status of held word
//   o_rx_overrun                    1-cycle pulse when a completed frame is dropped
//   o_rx_busy                       RX inside a frame
module uart_ctrl #(
    parameter int unsigned G_OVERSAMPLE = 16,
    parameter int unsigned G_WORD_WIDTH = 8,
    parameter int unsigned G_DIV_WIDTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [G_DIV_WIDTH-1:0]  i_baud_div,
    input  logic [1:0]              i_parity_mode,
    input  logic                    i_two_stop,
    input  logic                    i_tx_valid,
    output logic                    o_tx_ready,
    input  logic [G_WORD_WIDTH-1:0] i_tx_data,
    output logic                    o_tx,
    output logic                    o_tx_busy,
    input  logic                    i_rx,
    output logic                    o_rx_valid,
    input  logic                    i_rx_ready,
    output logic [G_WORD_WIDTH-1:0] o_rx_data,
    output logic                    o_rx_parity_err,
    output logic                    o_rx_frame_err,
    output logic                    o_rx_break,
    output logic                    o_rx_overrun,
    output logic                    o_rx_busy
);
    localparam int unsigned OsW  = $clog2(G_OVERSAMPLE);
    localparam int unsigned BitW = $clog2(G_WORD_WIDTH);
    localparam logic [OsW-1:0]  OsLast   = OsW'(G_OVERSAMPLE - 1);
    localparam logic [OsW-1:0]  OsHalfM1 = OsW'(G_OVERSAMPLE / 2 - 1);
    localparam logic [BitW-1:0] BitLast  = BitW'(G_WORD_WIDTH - 1);

    // ---------------------------------------------------------------- TX
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

    tx_state_e               tx_state_q;
    logic [G_DIV_WIDTH-1:0]  tx_div_q;
    logic [OsW-1:0]          tx_os_q;
    logic [BitW-1:0]         tx_bit_q;
    logic [G_WORD_WIDTH-1:0] tx_shift_q;
    logic                    tx_par_en_q, tx_par_bit_q, tx_two_q, tx_stop2_q;
    logic                    tx_q, tx_ready_q, tx_busy_q;
    logic                    tx_tick, tx_bit_end;

    // >= so that a divisor shrunk below the current count still ticks.
    assign tx_tick    = (tx_div_q >= i_baud_div);
    assign tx_bit_end = tx_tick && (tx_os_q == OsLast);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state_q   <= TxIdle;
            tx_div_q     <= '0;
            tx_os_q      <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_par_en_q  <= 1'b0;
            tx_par_bit_q <= 1'b0;
            tx_two_q     <= 1'b0;
            tx_stop2_q   <= 1'b0;
            tx_q         <= 1'b1;
            tx_ready_q   <= 1'b1;
            tx_busy_q    <= 1'b0;
        end else if (tx_state_q == TxIdle) begin
            // Prescaler held at zero so it restarts exactly at acceptance.
            tx_div_q <= '0;
            tx_os_q  <= '0;
            if (i_tx_valid && tx_ready_q) begin
                tx_shift_q   <= i_tx_data;
                tx_par_en_q  <= ^i_parity_mode;
                tx_par_bit_q <= (^i_tx_data) ^ i_parity_mode[1];
                tx_two_q     <= i_two_stop;
                tx_stop2_q   <= 1'b0;
                tx_state_q   <= TxStart;
                tx_q         <= 1'b0;
                tx_ready_q   <= 1'b0;
                tx_busy_q    <= 1'b1;
            end
        end else begin
            tx_div_q <= tx_tick ? '0 : tx_div_q + 1'b1;
            if (tx_tick) tx_os_q <= tx_os_q + 1'b1;
            if (tx_bit_end) begin
                case (tx_state_q)
                    TxStart: begin
                        tx_state_q <= TxData;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                    end
                    TxData: begin
                        if (tx_bit_q == BitLast) begin
                            tx_state_q <= tx_par_en_q ? TxParity : TxStop;
                            tx_q       <= tx_par_en_q ? tx_par_bit_q : 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 1'b1;
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_q       <= tx_shift_q[1];
                        end
                    end
                    TxParity: begin
                        tx_state_q <= TxStop;
                        tx_q       <= 1'b1;
                    end
                    TxStop: begin
                        if (tx_two_q && !tx_stop2_q) begin
                            tx_stop2_q <= 1'b1;
                        end else begin
                            tx_state_q <= TxIdle;
                            tx_ready_q <= 1'b1;
                            tx_busy_q  <= 1'b0;
                        end
                    end
                    default: tx_state_q <= TxIdle;
                endcase
            end
        end
    end

    assign o_tx       = tx_q;
    assign o_tx_ready = tx_ready_q;
    assign o_tx_busy  = tx_busy_q;

    // ---------------------------------------------------------------- RX
    typedef enum logic [2:0] {
        RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh
    } rx_state_e;

    rx_state_e               rx_state_q;
    logic [1:0]              rx_sync_q;
    logic [G_DIV_WIDTH-1:0]  rx_div_q;
    logic [OsW-1:0]          rx_os_q, rx_low_q;
    logic [BitW-1:0]         rx_bit_q;
    logic [G_WORD_WIDTH-1:0] rx_shift_q, rx_data_q;
    logic                    rx_par_en_q, rx_par_odd_q, rx_par_bit_q, rx_busy_q;
    logic                    rx_valid_q, rx_perr_q, rx_ferr_q, rx_brk_q, rx_overrun_q;
    logic                    rx_s, rx_tick, rx_sample, rx_done;
    logic                    rx_perr, rx_ferr, rx_brk;

    assign rx_s      = rx_sync_q[1];
    assign rx_tick   = (rx_div_q >= i_baud_div);
    assign rx_sample = rx_tick && (rx_os_q == OsLast);
    assign rx_done   = (rx_state_q == RxStop) && rx_sample;

    // Frame status, valid in the stop-bit sample cycle.
    assign rx_ferr = ~rx_s;
    assign rx_perr = rx_par_en_q && (rx_par_bit_q != ((^rx_shift_q) ^ rx_par_odd_q));
    assign rx_brk  = ~rx_s && (rx_shift_q == '0) && !rx_par_bit_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_sync_q    <= 2'b11;
            rx_div_q     <= '0;
            rx_state_q   <= RxIdle;
            rx_os_q      <= '0;
            rx_low_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_par_bit_q <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], i_rx};
            rx_div_q  <= rx_tick ? '0 : rx_div_q + 1'b1;
            if (rx_tick) rx_os_q <= rx_os_q + 1'b1;
            case (rx_state_q)
                RxIdle: begin
                    rx_os_q <= '0;
                    if (rx_tick) begin
                        if (rx_s) begin
                            rx_low_q <= '0;
                        end else if (rx_low_q == OsHalfM1) begin
                            // Mid-start-bit: sampling phase is anchored here.
                            rx_low_q     <= '0;
                            rx_state_q   <= RxStart;
                            rx_par_en_q  <= ^i_parity_mode;
                            rx_par_odd_q <= i_parity_mode[1];
                            rx_par_bit_q <= 1'b0;
                            rx_busy_q    <= 1'b1;
                        end else begin
                            rx_low_q <= rx_low_q + 1'b1;
                        end
                    end
                end
                // START waits one bit from the start-bit centre, then takes data bit 0.
                RxStart: begin
                    if (rx_sample) begin
                        rx_shift_q <= {rx_s, rx_shift_q[G_WORD_WIDTH-1:1]};
                        rx_bit_q   <= BitW'(1);
                        rx_state_q <= RxData;
                    end
                end
                RxData: begin
                    if (rx_sample) begin
                        rx_shift_q <= {rx_s, rx_shift_q[G_WORD_WIDTH-1:1]};
                        rx_bit_q   <= rx_bit_q + 1'b1;
                        if (rx_bit_q == BitLast) begin
                            rx_state_q <= rx_par_en_q ? RxParity : RxStop;
                        end
                    end
                end
                RxParity: begin
                    if (rx_sample) begin
                        rx_par_bit_q <= rx_s;
                        rx_state_q   <= RxStop;
                    end
                end
                RxStop: begin
                    if (rx_sample) begin
                        if (rx_brk) begin
                            rx_state_q <= RxWaitHigh;
                        end else begin
                            rx_state_q <= RxIdle;
                            rx_busy_q  <= 1'b0;
                        end
                    end
                end
                RxWaitHigh: begin
                    // A held-low line must return high before a new start is searched for.
                    if (rx_tick && rx_s) begin
                        rx_state_q <= RxIdle;
                        rx_busy_q  <= 1'b0;
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // One-entry holding register; a same-cycle accept frees room for the new frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_perr_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
            rx_brk_q     <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            rx_overrun_q <= rx_done && rx_valid_q && !i_rx_ready;
            if (rx_done && (!rx_valid_q || i_rx_ready)) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= rx_shift_q;
                rx_perr_q  <= rx_perr;
                rx_ferr_q  <= rx_ferr;
                rx_brk_q   <= rx_brk;
            end else if (rx_valid_q && i_rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign o_rx_valid      = rx_valid_q;
    assign o_rx_data       = rx_data_q;
    assign o_rx_parity_err = rx_perr_q;
    assign o_rx_frame_err  = rx_ferr_q;
    assign o_rx_break      = rx_brk_q;
    assign o_rx_overrun    = rx_overrun_q;
    assign o_rx_busy       = rx_busy_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: self-checking bench for uart_ctrl (G_OVERSAMPLE=16, 8-bit words, div=3).
//   TX frames are checked bit-by-bit from a vector table; RX results go through a
//   scoreboard queue filled when stimulus is driven and drained by a monitor.
module tb_uart_ctrl;
    localparam int BitCyc = 64;  // (3+1)*16

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        two_stop, tx_valid, tx_ready, tx, tx_busy;
    logic [7:0]  tx_data, rx_data;
    logic        rx_line, rx_drv, loop_en;
    logic        rx_valid, rx_ready, pe, fe, brk, ovr, rx_busy;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int ovr_cnt = 0;
    int busy_seen = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       brk;
    } rx_exp_t;
    rx_exp_t sb[$];

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic       two;
        logic       par;    // expected parity bit (ignored when mode has none)
        int         nbits;  // expected frame length in bit periods
    } tx_vec_t;
    tx_vec_t tx_vecs[6];

    always #5 clk = ~clk;
    assign rx_line = loop_en ? tx : rx_drv;

    uart_ctrl #(
        .G_OVERSAMPLE(16),
        .G_WORD_WIDTH(8),
        .G_DIV_WIDTH (16)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_baud_div     (baud_div),
        .i_parity_mode  (parity_mode),
        .i_two_stop     (two_stop),
        .i_tx_valid     (tx_valid),
        .o_tx_ready     (tx_ready),
        .i_tx_data      (tx_data),
        .o_tx           (tx),
        .o_tx_busy      (tx_busy),
        .i_rx           (rx_line),
        .o_rx_valid     (rx_valid),
        .i_rx_ready     (rx_ready),
        .o_rx_data      (rx_data),
        .o_rx_parity_err(pe),
        .o_rx_frame_err (fe),
        .o_rx_break     (brk),
        .o_rx_overrun   (ovr),
        .o_rx_busy      (rx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one pop per accepted word.
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            rx_exp_t e;
            valid_cnt++;
            check("rx_sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rx_word", {rx_data, pe, fe, brk}, e);
            end
        end
        if (rst_n && ovr) ovr_cnt++;
        if (rst_n && rx_busy) busy_seen++;
    end

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic send_tx(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", 32'(tx_ready), 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    // Bench-driven RX frame; a low stop bit is only held past its sample point.
    task automatic send_rx(input logic [7:0] d, input logic has_par, input logic par,
                           input logic stop);
        rx_drv = 1'b0;
        repeat (BitCyc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (BitCyc) @(negedge clk);
        end
        if (has_par) begin
            rx_drv = par;
            repeat (BitCyc) @(negedge clk);
        end
        rx_drv = stop;
        repeat (stop ? BitCyc : 44) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * BitCyc) @(negedge clk);
    endtask

    task automatic run_tx_vec(input tx_vec_t v);
        logic [11:0] eb;
        int          lowcnt;
        logic        ok;
        eb = '1;
        eb[0] = 1'b0;
        for (int i = 0; i < 8; i++) eb[i+1] = v.data[i];
        if (v.mode == 2'b01 || v.mode == 2'b10) eb[9] = v.par;
        parity_mode = v.mode;
        two_stop    = v.two;
        send_tx(v.data);
        // Config changes after acceptance must not affect the frame in flight.
        parity_mode = ~v.mode;
        two_stop    = ~v.two;
        lowcnt = 0;
        for (int k = 0; k < v.nbits; k++) begin
            ok = 1'b1;
            for (int c = 0; c < BitCyc; c++) begin
                @(negedge clk);
                if (tx !== eb[k]) ok = 1'b0;
                if (!tx_ready && tx_busy) lowcnt++;
            end
            check($sformatf("tx_bit%0d_%02h", k, v.data), 32'(ok), 1);
        end
        check($sformatf("tx_ready_low_%02h", v.data), lowcnt, v.nbits * BitCyc);
        @(negedge clk);
        check("tx_idle_after", {tx_ready, tx_busy, tx}, 3'b101);
    endtask

    initial begin
        int vc0;
        int ov0;
        rst_n = 1'b0; baud_div = 16'd3; parity_mode = 2'b01; two_stop = 1'b0;
        tx_valid = 1'b0; tx_data = '0; rx_drv = 1'b1; loop_en = 1'b0; rx_ready = 1'b1;

        tx_vecs[0] = '{8'hA5, 2'b01, 1'b0, 1'b0, 11};
        tx_vecs[1] = '{8'hA5, 2'b10, 1'b1, 1'b1, 12};
        tx_vecs[2] = '{8'h3C, 2'b00, 1'b0, 1'b0, 10};
        tx_vecs[3] = '{8'h07, 2'b11, 1'b1, 1'b0, 11};
        tx_vecs[4] = '{8'h80, 2'b01, 1'b0, 1'b1, 11};
        tx_vecs[5] = '{8'h00, 2'b10, 1'b0, 1'b1, 11};

        repeat (3) @(negedge clk);
        check("reset_state", {tx, tx_ready, tx_busy, rx_valid, rx_data, pe, fe, brk, ovr, rx_busy},
              {1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // TX waveform table
        for (int i = 0; i < 6; i++) run_tx_vec(tx_vecs[i]);

        // Loopback, odd parity, two stop bits, back-to-back
        loop_en = 1'b1; parity_mode = 2'b10; two_stop = 1'b1;
        vc0 = valid_cnt;
        sb.push_back('{8'h3C, 1'b0, 1'b0, 1'b0}); send_tx(8'h3C);
        sb.push_back('{8'h00, 1'b0, 1'b0, 1'b0}); send_tx(8'h00);
        sb.push_back('{8'hFF, 1'b0, 1'b0, 1'b0}); send_tx(8'hFF);
        drain("loop_drain", 3000);
        check("loop_valid_count", valid_cnt - vc0, 3);
        loop_en = 1'b0;
        repeat (BitCyc) @(negedge clk);

        // Parity and framing errors, even parity
        parity_mode = 2'b01; two_stop = 1'b0;
        sb.push_back('{8'h55, 1'b1, 1'b0, 1'b0}); send_rx(8'h55, 1'b1, 1'b1, 1'b1);
        sb.push_back('{8'h12, 1'b0, 1'b1, 1'b0}); send_rx(8'h12, 1'b1, 1'b0, 1'b0);
        drain("err_drain", 200);

        // Break: line low for 20 bit periods
        vc0 = valid_cnt;
        sb.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
        rx_drv = 1'b0;
        repeat (20 * BitCyc) @(negedge clk);
        check("break_one_valid", valid_cnt - vc0, 1);
        rx_drv = 1'b1;
        repeat (2 * BitCyc) @(negedge clk);
        check("break_no_more", valid_cnt - vc0, 1);
        sb.push_back('{8'h5A, 1'b0, 1'b0, 1'b0}); send_rx(8'h5A, 1'b1, 1'b0, 1'b1);
        drain("break_drain", 200);
        check("after_break_valid", valid_cnt - vc0, 2);

        // Glitch reject: 5 ticks low
        vc0 = valid_cnt; busy_seen = 0;
        rx_drv = 1'b0;
        repeat (20) @(negedge clk);
        rx_drv = 1'b1;
        repeat (4 * BitCyc) @(negedge clk);
        check("glitch_busy", busy_seen, 0);
        check("glitch_valid", valid_cnt - vc0, 0);

        // Overrun: two frames without consumer
        rx_ready = 1'b0; ov0 = ovr_cnt;
        send_rx(8'h81, 1'b1, 1'b0, 1'b1);
        check("ovr_first_held", {rx_valid, rx_data}, {1'b1, 8'h81});
        send_rx(8'h7E, 1'b1, 1'b0, 1'b1);
        check("ovr_pulses", ovr_cnt - ov0, 1);
        check("ovr_word_kept", {rx_valid, rx_data, pe, fe, brk}, {1'b1, 8'h81, 3'b000});
        sb.push_back('{8'h81, 1'b0, 1'b0, 1'b0});
        rx_ready = 1'b1;
        drain("ovr_drain", 10);
        @(negedge clk);
        check("ovr_cleared", 32'(rx_valid), 0);

        // Reset mid-frame on both directions with a word held
        rx_ready = 1'b0;
        send_rx(8'h33, 1'b1, 1'b0, 1'b1);
        check("rst_held_before", 32'(rx_valid), 1);
        loop_en = 1'b1; parity_mode = 2'b10; two_stop = 1'b0;
        send_tx(8'h96);
        repeat (4 * BitCyc) @(negedge clk);
        check("rst_mid_busy", {rx_busy, tx_busy}, 2'b11);
        #2 rst_n = 1'b0;
        #1 check("rst_async", {tx, tx_ready, tx_busy, rx_valid, rx_busy, ovr, rx_data},
                 {6'b110000, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        sb.push_back('{8'hC3, 1'b0, 1'b0, 1'b0}); send_tx(8'hC3);
        drain("rst_after_drain", 1500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
